// File: rtl/seeg_pkg.sv
// Shared definitions for the seeg host register bank.
//   - register map addresses and CTRL/STATUS bit positions
//   - pulse stretcher counter width and FSM state type
//   - stim configuration record (one copy is the shadow set, one the active set)
//   - reset value and validation helpers for that record
package seeg_pkg;

  localparam int unsigned PULSE_CNT_W      = 8;
  localparam int unsigned REG_ADDR_W       = 5;
  localparam logic [1:0]  ZCHECK_SCALE_RST = 2'b11;

  // Register map
  localparam logic [REG_ADDR_W-1:0] A_CTRL          = 5'h00;
  localparam logic [REG_ADDR_W-1:0] A_PULSE_LEN     = 5'h01;
  localparam logic [REG_ADDR_W-1:0] A_MAGNITUDE     = 5'h02;
  localparam logic [REG_ADDR_W-1:0] A_INTER_BIPULSE = 5'h03;
  localparam logic [REG_ADDR_W-1:0] A_INTER_PULSE   = 5'h04;
  localparam logic [REG_ADDR_W-1:0] A_INTER_TRAIN   = 5'h05;
  localparam logic [REG_ADDR_W-1:0] A_BIPULSES      = 5'h06;
  localparam logic [REG_ADDR_W-1:0] A_TRAIN_CNT     = 5'h07;
  localparam logic [REG_ADDR_W-1:0] A_CHARGE_REC    = 5'h08;
  localparam logic [REG_ADDR_W-1:0] A_MODE          = 5'h09;
  localparam logic [REG_ADDR_W-1:0] A_MASK_POS      = 5'h0A;
  localparam logic [REG_ADDR_W-1:0] A_MASK_NEG      = 5'h0B;
  localparam logic [REG_ADDR_W-1:0] A_STEP_SIZE     = 5'h0C;
  localparam logic [REG_ADDR_W-1:0] A_PROBE_SEL     = 5'h0D;
  localparam logic [REG_ADDR_W-1:0] A_STATUS        = 5'h0E;

  // CTRL strobe bits
  localparam int unsigned CTRL_REC_START = 0;
  localparam int unsigned CTRL_REC_STOP  = 1;
  localparam int unsigned CTRL_ZCHECK    = 2;
  localparam int unsigned CTRL_FIN_START = 3;
  localparam int unsigned CTRL_INF_START = 4;
  localparam int unsigned CTRL_INF_STOP  = 5;
  localparam int unsigned CTRL_COMMIT    = 6;
  localparam int unsigned CTRL_CLR_ERR   = 7;

  // STATUS bits
  localparam int unsigned ST_STIM_BUSY      = 0;
  localparam int unsigned ST_ERR_GATE       = 1;
  localparam int unsigned ST_ERR_CFG        = 2;
  localparam int unsigned ST_CFG_VALID      = 3;
  localparam int unsigned ST_COMMIT_PENDING = 4;

  typedef enum logic {
    PS_IDLE,
    PS_HIGH
  } pulse_state_e;

  typedef struct packed {
    logic [15:0] pulse_len;
    logic [7:0]  magnitude;
    logic [15:0] inter_bipulse;
    logic [15:0] inter_pulse;
    logic [15:0] inter_train;
    logic [15:0] bipulses;
    logic [15:0] train_cnt;
    logic [15:0] charge_rec;
    logic        loopback;
    logic        bipolar;
    logic        rising_first;
    logic [1:0]  zcheck_scale;
    logic [15:0] mask_pos;
    logic [15:0] mask_neg;
    logic [15:0] step_size;
    logic [15:0] probe_sel;
  } stim_cfg_t;

  function automatic stim_cfg_t cfg_reset_value();
    stim_cfg_t c;
    c              = '0;
    c.zcheck_scale = ZCHECK_SCALE_RST;
    return c;
  endfunction

  // A bipolar configuration must not drive one channel on both polarities.
  function automatic logic cfg_is_valid(input stim_cfg_t c);
    logic ok;
    ok = (c.pulse_len != '0) && (c.bipulses != '0) && (c.train_cnt != '0) &&
         (c.mask_pos != '0) && !(c.bipolar && ((c.mask_pos & c.mask_neg) != '0));
    return ok;
  endfunction

endpackage

// File: rtl/seeg_pulse_stretch.sv
// Turns a single-cycle strobe into a PULSE_CYCLES-wide registered pulse.
//   clk_i    : system clock
//   rst_i    : asynchronous reset, active-high
//   strobe_i : single-cycle request; a strobe while high restarts the width
//   pulse_o  : registered pulse, high for PULSE_CYCLES cycles after the strobe
module seeg_pulse_stretch
  import seeg_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  output logic pulse_o
);

  localparam logic [PULSE_CNT_W-1:0] LOAD = PULSE_CNT_W'(PULSE_CYCLES);

  pulse_state_e           state_q;
  logic [PULSE_CNT_W-1:0] cnt_q;
  logic                   pulse_q;

  // The counter holds the number of high cycles remaining including the
  // current one, so the output drops on the edge that would reach zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PS_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      case (state_q)
        PS_IDLE: begin
          if (strobe_i) begin
            state_q <= PS_HIGH;
            cnt_q   <= LOAD;
            pulse_q <= 1'b1;
          end
        end
        PS_HIGH: begin
          if (strobe_i) begin
            cnt_q <= LOAD;
          end else if (cnt_q <= 8'd1) begin
            state_q <= PS_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= PS_IDLE;
          cnt_q   <= '0;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/seeg_ctrl_regs.sv
// Host register bank in front of seeg.
//   Host bus : wr_en/rd_en/addr/wdata in, rdata/rd_valid out (1-cycle read latency)
//   stim_busy: seeg stim engine running; blocks starts and defers commits
//   Pulses   : record_start/stop, zcheck_start, stim finite/infinite start, infinite stop
//   Active   : stim_* / loopback_mode / zcheck_scale configuration driving seeg
//   cfg_valid: a validated configuration has been made active since reset
// The host edits a shadow set, then COMMIT validates it and copies it
// atomically to the active set (deferred while stim_busy is high).
module seeg_ctrl_regs
  import seeg_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 16,
  parameter int unsigned ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              rd_valid,
  input  logic              stim_busy,
  output logic              record_start,
  output logic              record_stop,
  output logic              zcheck_start,
  output logic              stim_finite_mode_start,
  output logic              stim_infinite_mode_start,
  output logic              stim_infinite_mode_stop,
  output logic [15:0]       stim_pulse_length,
  output logic [15:0]       stim_inter_bipulse_delay,
  output logic [15:0]       stim_inter_pulse_delay,
  output logic [15:0]       stim_inter_train_delay,
  output logic [15:0]       stim_bipulses_per_train_count,
  output logic [15:0]       stim_train_count,
  output logic [15:0]       stim_charge_recovery_time,
  output logic [15:0]       stim_current_step_size,
  output logic [15:0]       stim_mask_channel_positive,
  output logic [15:0]       stim_mask_channel_negative,
  output logic [15:0]       stim_mask_probe_select,
  output logic [7:0]        stim_pulse_magnitude,
  output logic              stim_rising_edge_first,
  output logic              stim_bipolar_mode,
  output logic              loopback_mode,
  output logic [1:0]        zcheck_scale,
  output logic              cfg_valid
);

  stim_cfg_t   shadow_q, shadow_d;
  stim_cfg_t   active_q, active_d;
  logic        cfg_valid_q, cfg_valid_d;
  logic        pending_q, pending_d;
  logic        err_cfg_q, err_cfg_d;
  logic        err_gate_q, err_gate_d;
  logic [15:0] rdata_q;
  logic        rd_valid_q;

  logic [7:0]  strb;
  logic        shadow_ok;
  logic        copy_now;
  logic        gate_ok;
  logic        start_conflict;
  logic        inf_start_req;
  logic [5:0]  go;
  logic [5:0]  pulse;
  logic [15:0] rd_mux;
  logic [15:0] status;

  assign strb      = (wr_en && (addr == A_CTRL)) ? wdata[7:0] : '0;
  assign shadow_ok = cfg_is_valid(shadow_q);

  // Shadow register writes
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      case (addr)
        A_PULSE_LEN:     shadow_d.pulse_len     = wdata;
        A_MAGNITUDE:     shadow_d.magnitude     = wdata[7:0];
        A_INTER_BIPULSE: shadow_d.inter_bipulse = wdata;
        A_INTER_PULSE:   shadow_d.inter_pulse   = wdata;
        A_INTER_TRAIN:   shadow_d.inter_train   = wdata;
        A_BIPULSES:      shadow_d.bipulses      = wdata;
        A_TRAIN_CNT:     shadow_d.train_cnt     = wdata;
        A_CHARGE_REC:    shadow_d.charge_rec    = wdata;
        A_MODE: begin
          shadow_d.loopback     = wdata[4];
          shadow_d.bipolar      = wdata[3];
          shadow_d.rising_first = wdata[2];
          shadow_d.zcheck_scale = wdata[1:0];
        end
        A_MASK_POS:      shadow_d.mask_pos      = wdata;
        A_MASK_NEG:      shadow_d.mask_neg      = wdata;
        A_STEP_SIZE:     shadow_d.step_size     = wdata;
        A_PROBE_SEL:     shadow_d.probe_sel     = wdata;
        default:         shadow_d = shadow_q;
      endcase
    end
  end

  // Commit, gating and error flags. Commit is resolved first so that starts
  // in the same CTRL write see the post-commit cfg_valid / pending state.
  always_comb begin
    active_d       = active_q;
    cfg_valid_d    = cfg_valid_q;
    pending_d      = pending_q;
    err_cfg_d      = strb[CTRL_CLR_ERR] ? 1'b0 : err_cfg_q;
    err_gate_d     = strb[CTRL_CLR_ERR] ? 1'b0 : err_gate_q;
    copy_now       = 1'b0;

    if (pending_q && !stim_busy) begin
      copy_now  = 1'b1;
      pending_d = 1'b0;
    end

    if (strb[CTRL_COMMIT]) begin
      if (!shadow_ok) begin
        err_cfg_d = 1'b1;
      end else if (stim_busy) begin
        pending_d = 1'b1;
      end else begin
        copy_now = 1'b1;
      end
    end

    if (copy_now) begin
      active_d    = shadow_q;
      cfg_valid_d = 1'b1;
    end

    gate_ok        = cfg_valid_d && !stim_busy && !pending_d;
    start_conflict = strb[CTRL_FIN_START] && strb[CTRL_INF_START];
    inf_start_req  = strb[CTRL_INF_START] && !strb[CTRL_INF_STOP];

    if (start_conflict ||
        (strb[CTRL_FIN_START] && !gate_ok) ||
        (inf_start_req && !gate_ok)) begin
      err_gate_d = 1'b1;
    end

    go                 = '0;
    go[CTRL_REC_START] = strb[CTRL_REC_START] && !strb[CTRL_REC_STOP];
    go[CTRL_REC_STOP]  = strb[CTRL_REC_STOP];
    go[CTRL_ZCHECK]    = strb[CTRL_ZCHECK];
    go[CTRL_FIN_START] = strb[CTRL_FIN_START] && !start_conflict && gate_ok;
    go[CTRL_INF_START] = inf_start_req && !start_conflict && gate_ok;
    go[CTRL_INF_STOP]  = strb[CTRL_INF_STOP];
  end

  // Read mux
  always_comb begin
    status                    = '0;
    status[ST_STIM_BUSY]      = stim_busy;
    status[ST_ERR_GATE]       = err_gate_q;
    status[ST_ERR_CFG]        = err_cfg_q;
    status[ST_CFG_VALID]      = cfg_valid_q;
    status[ST_COMMIT_PENDING] = pending_q;

    rd_mux = '0;
    case (addr)
      A_PULSE_LEN:     rd_mux = shadow_q.pulse_len;
      A_MAGNITUDE:     rd_mux = {8'h00, shadow_q.magnitude};
      A_INTER_BIPULSE: rd_mux = shadow_q.inter_bipulse;
      A_INTER_PULSE:   rd_mux = shadow_q.inter_pulse;
      A_INTER_TRAIN:   rd_mux = shadow_q.inter_train;
      A_BIPULSES:      rd_mux = shadow_q.bipulses;
      A_TRAIN_CNT:     rd_mux = shadow_q.train_cnt;
      A_CHARGE_REC:    rd_mux = shadow_q.charge_rec;
      A_MODE:          rd_mux = {11'h000, shadow_q.loopback, shadow_q.bipolar,
                                 shadow_q.rising_first, shadow_q.zcheck_scale};
      A_MASK_POS:      rd_mux = shadow_q.mask_pos;
      A_MASK_NEG:      rd_mux = shadow_q.mask_neg;
      A_STEP_SIZE:     rd_mux = shadow_q.step_size;
      A_PROBE_SEL:     rd_mux = shadow_q.probe_sel;
      A_STATUS:        rd_mux = status;
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q    <= cfg_reset_value();
      active_q    <= cfg_reset_value();
      cfg_valid_q <= 1'b0;
      pending_q   <= 1'b0;
      err_cfg_q   <= 1'b0;
      err_gate_q  <= 1'b0;
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      cfg_valid_q <= cfg_valid_d;
      pending_q   <= pending_d;
      err_cfg_q   <= err_cfg_d;
      err_gate_q  <= err_gate_d;
      rd_valid_q  <= rd_en;
      if (rd_en) begin
        rdata_q <= rd_mux;
      end
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_pulse
    seeg_pulse_stretch #(
      .PULSE_CYCLES(PULSE_CYCLES)
    ) u_stretch (
      .clk_i   (clk),
      .rst_i   (rst),
      .strobe_i(go[g]),
      .pulse_o (pulse[g])
    );
  end

  assign record_start             = pulse[CTRL_REC_START];
  assign record_stop              = pulse[CTRL_REC_STOP];
  assign zcheck_start             = pulse[CTRL_ZCHECK];
  assign stim_finite_mode_start   = pulse[CTRL_FIN_START];
  assign stim_infinite_mode_start = pulse[CTRL_INF_START];
  assign stim_infinite_mode_stop  = pulse[CTRL_INF_STOP];

  assign stim_pulse_length             = active_q.pulse_len;
  assign stim_pulse_magnitude          = active_q.magnitude;
  assign stim_inter_bipulse_delay      = active_q.inter_bipulse;
  assign stim_inter_pulse_delay        = active_q.inter_pulse;
  assign stim_inter_train_delay        = active_q.inter_train;
  assign stim_bipulses_per_train_count = active_q.bipulses;
  assign stim_train_count              = active_q.train_cnt;
  assign stim_charge_recovery_time     = active_q.charge_rec;
  assign loopback_mode                 = active_q.loopback;
  assign stim_bipolar_mode             = active_q.bipolar;
  assign stim_rising_edge_first        = active_q.rising_first;
  assign zcheck_scale                  = active_q.zcheck_scale;
  assign stim_mask_channel_positive    = active_q.mask_pos;
  assign stim_mask_channel_negative    = active_q.mask_neg;
  assign stim_current_step_size        = active_q.step_size;
  assign stim_mask_probe_select        = active_q.probe_sel;

  assign cfg_valid = cfg_valid_q;
  assign rdata     = rdata_q;
  assign rd_valid  = rd_valid_q;

endmodule
